// File: rtl/i2cmb_cmd_queue.sv
// I2CMB command/response queue: buffers byte-level commands, issues them one at a time to the
// byte controller and queues the outcomes. Optional watchdog enabled by I2CMB_CMD_TIMEOUT_EN.
module i2cmb_cmd_queue #(
    parameter int DATA_W         = 8,
    parameter int CMD_DEPTH      = 8,
    parameter int RSP_DEPTH      = 8,
    parameter int NUM_BUSES      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [2:0]                   cmd_code_i,
    input  logic [DATA_W-1:0]            cmd_data_i,
    input  logic                         flush_i,
    output logic                         bc_valid_o,
    output logic [2:0]                   bc_code_o,
    output logic [DATA_W-1:0]            bc_data_o,
    input  logic                         bc_done_i,
    input  logic                         bc_nak_i,
    input  logic                         bc_al_i,
    input  logic [DATA_W-1:0]            bc_rdata_i,
    output logic [$clog2(NUM_BUSES)-1:0] bus_sel_o,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [1:0]                   rsp_code_o,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count_o
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int BSW = $clog2(NUM_BUSES);

    localparam logic [2:0] OP_READ_ACK = 3'd3;
    localparam logic [2:0] OP_READ_NAK = 3'd4;
    localparam logic [2:0] OP_SET_BUS  = 3'd5;
    localparam logic [2:0] OP_RSVD     = 3'd7;
    localparam logic [1:0] RSP_DONE    = 2'd0;
    localparam logic [1:0] RSP_NAK     = 2'd1;
    localparam logic [1:0] RSP_AL      = 2'd2;
    localparam logic [1:0] RSP_ERR     = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ABORT} state_t;
    state_t state, state_nxt;

    logic [2:0]        cmd_code_mem [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_data_mem [CMD_DEPTH];
    logic [CAW-1:0]    cmd_wr, cmd_rd;
    logic [CAW:0]      cmd_cnt;
    logic [1:0]        rsp_code_mem [RSP_DEPTH];
    logic [DATA_W-1:0] rsp_data_mem [RSP_DEPTH];
    logic [RAW-1:0]    rsp_wr, rsp_rd;
    logic [RAW:0]      rsp_cnt;

    logic              cmd_push, cmd_pop, cmd_drop, rsp_push, rsp_pop;
    logic              bus_load, bc_load, bc_clear, wd_expire;
    logic [2:0]        head_code;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        rsp_code_new;
    logic [DATA_W-1:0] rsp_data_new;

    assign head_code   = cmd_code_mem[cmd_rd];
    assign head_data   = cmd_data_mem[cmd_rd];
    assign cmd_ready_o = (cmd_cnt != (CAW+1)'(CMD_DEPTH));
    assign cmd_count_o = cmd_cnt;
    assign cmd_push    = cmd_valid_i && cmd_ready_o && !flush_i;
    assign rsp_valid_o = (rsp_cnt != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;
    assign rsp_code_o  = rsp_code_mem[rsp_rd];
    assign rsp_data_o  = rsp_data_mem[rsp_rd];

`ifdef I2CMB_CMD_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wdog;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                wdog <= '0;
        else if (bc_load)                         wdog <= '0;
        else if (state == WAIT_DONE && !wd_expire) wdog <= wdog + 1'b1;
    end

    assign wd_expire = (state == WAIT_DONE) && (32'(wdog) == 32'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cmd_cnt != '0 && rsp_cnt != (RAW+1)'(RSP_DEPTH)) state_nxt = ISSUE;
            ISSUE:     state_nxt = bc_load ? WAIT_DONE : IDLE;
            WAIT_DONE: if (rsp_push) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // Failed outcomes flush the rest of the sequence rather than running it blind.
        if (rsp_push && (rsp_code_new == RSP_AL || rsp_code_new == RSP_ERR)) state_nxt = ABORT;
        if (flush_i) state_nxt = IDLE;
    end

    always_comb begin
        cmd_pop      = 1'b0;
        cmd_drop     = 1'b0;
        rsp_push     = 1'b0;
        bus_load     = 1'b0;
        bc_load      = 1'b0;
        bc_clear     = 1'b0;
        rsp_code_new = RSP_DONE;
        rsp_data_new = '0;
        case (state)
            ISSUE: begin
                cmd_pop = 1'b1;
                if (head_code == OP_SET_BUS) begin
                    rsp_push = 1'b1;
                    if (32'(head_data) < 32'(NUM_BUSES)) bus_load = 1'b1;
                    else                                 rsp_code_new = RSP_ERR;
                end else if (head_code == OP_RSVD) begin
                    rsp_push     = 1'b1;
                    rsp_code_new = RSP_ERR;
                end else begin
                    bc_load = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bc_done_i) begin
                    rsp_push = 1'b1;
                    bc_clear = 1'b1;
                    if (bc_al_i)       rsp_code_new = RSP_AL;
                    else if (bc_nak_i) rsp_code_new = RSP_NAK;
                    if (bc_code_o == OP_READ_ACK || bc_code_o == OP_READ_NAK) rsp_data_new = bc_rdata_i;
                end else if (wd_expire) begin
                    rsp_push     = 1'b1;
                    bc_clear     = 1'b1;
                    rsp_code_new = RSP_ERR;
                end
            end
            ABORT:   cmd_drop = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            cmd_wr  <= '0;
            cmd_rd  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
            if (cmd_drop) begin
                cmd_rd  <= cmd_push ? cmd_wr + 1'b1 : cmd_wr;
                cmd_cnt <= '0;
            end else begin
                if (cmd_pop) cmd_rd <= cmd_rd + 1'b1;
                case ({cmd_push, cmd_pop})
                    2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                    2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            rsp_wr  <= '0;
            rsp_rd  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (rsp_push) rsp_wr <= rsp_wr + 1'b1;
            if (rsp_pop)  rsp_rd <= rsp_rd + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
                2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_code_mem[cmd_wr] <= cmd_code_i;
            cmd_data_mem[cmd_wr] <= cmd_data_i;
        end
        if (rsp_push && !flush_i) begin
            rsp_code_mem[rsp_wr] <= rsp_code_new;
            rsp_data_mem[rsp_wr] <= rsp_data_new;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bc_valid_o <= 1'b0;
            bc_code_o  <= '0;
            bc_data_o  <= '0;
            bus_sel_o  <= '0;
        end else if (flush_i) begin
            bc_valid_o <= 1'b0;
        end else begin
            if (bc_load) begin
                bc_valid_o <= 1'b1;
                bc_code_o  <= head_code;
                bc_data_o  <= head_data;
            end else if (bc_clear) begin
                bc_valid_o <= 1'b0;
            end
            if (bus_load) bus_sel_o <= head_data[BSW-1:0];
        end
    end
endmodule
